// File: rtl/pong_ball_engine.sv
// ============================================================================
// pong_ball_engine
//
// Ball engine for the Pong board. Moves the ball one board unit per step,
// bounces it off the top/bottom walls and both paddles, detects misses,
// emits hit/score pulses and re-serves automatically after a miss.
//
// Optional feature macro: BALL_SPEEDUP_EN
//   defined   : every paddle hit shortens the step period by SPEEDUP_STEP,
//               floored at MIN_PERIOD; the period returns to BALL_PERIOD on a
//               miss or when the game goes idle.
//   undefined : the step period is fixed at BALL_PERIOD.
//
// Ports
//   clk_i            : clock
//   rst_n_i          : asynchronous active-low reset
//   Game_Active_i    : high while a game is running; low forces IDLE
//   Serve_Dir_i      : X direction of the first serve (1 = right)
//   Paddle_Y_P1_i    : top row of the left paddle
//   Paddle_Y_P2_i    : top row of the right paddle
//   col_count_div_i  : board column currently being drawn
//   row_count_div_i  : board row currently being drawn
//   Draw_Ball_o      : registered, high when the drawn unit is the ball
//   Ball_X_o         : current ball column
//   Ball_Y_o         : current ball row
//   Hit_o            : one-cycle pulse on a paddle bounce
//   Score_P1_o       : one-cycle pulse when player 1 scores
//   Score_P2_o       : one-cycle pulse when player 2 scores
//   dbg_state_o      : current FSM state (0 IDLE, 1 SERVE, 2 MOVE, 3 MISS)
//
// Handshake: there is no valid/ready channel here. Inputs are sampled on
// every rising clk_i edge; every output is a plain registered level, and the
// three event outputs are single-cycle pulses with no back-pressure.
// ============================================================================
module pong_ball_engine #(
    parameter int GAME_WIDTH        = 40,
    parameter int GAME_HEIGHT       = 30,
    parameter int COORD_W           = 6,
    parameter int BALL_PERIOD       = 1250000,
    parameter int MIN_PERIOD        = 312500,
    parameter int SPEEDUP_STEP      = 125000,
    parameter int PADDLE_HEIGHT     = 6,
    parameter int PADDLE_COL_OFFSET = 0,
    parameter int SERVE_STEPS       = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               Game_Active_i,
    input  logic               Serve_Dir_i,
    input  logic [COORD_W-1:0] Paddle_Y_P1_i,
    input  logic [COORD_W-1:0] Paddle_Y_P2_i,
    input  logic [COORD_W-1:0] col_count_div_i,
    input  logic [COORD_W-1:0] row_count_div_i,
    output logic               Draw_Ball_o,
    output logic [COORD_W-1:0] Ball_X_o,
    output logic [COORD_W-1:0] Ball_Y_o,
    output logic               Hit_o,
    output logic               Score_P1_o,
    output logic               Score_P2_o,
    output logic [1:0]         dbg_state_o
);

    // The counter must hold every period value the configuration can reach,
    // so it is sized from the largest of the period-related parameters.
    localparam int SPAN_A      = (BALL_PERIOD > MIN_PERIOD) ? BALL_PERIOD : MIN_PERIOD;
    localparam int PERIOD_SPAN = (SPAN_A > SPEEDUP_STEP) ? SPAN_A : SPEEDUP_STEP;
    localparam int CNT_W       = $clog2(PERIOD_SPAN + 1);
    localparam int SRV_W       = $clog2(SERVE_STEPS + 1);

    localparam logic [COORD_W-1:0] CENTRE_X = COORD_W'(GAME_WIDTH / 2);
    localparam logic [COORD_W-1:0] CENTRE_Y = COORD_W'(GAME_HEIGHT / 2);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GAME_HEIGHT - 1);
    localparam logic [COORD_W-1:0] P1_HIT_X = COORD_W'(PADDLE_COL_OFFSET + 1);
    localparam logic [COORD_W-1:0] P2_HIT_X = COORD_W'(GAME_WIDTH - 2 - PADDLE_COL_OFFSET);
    localparam logic [COORD_W-1:0] POS_ONE  = COORD_W'(1);
    localparam logic [COORD_W:0]   PAD_LEN  = (COORD_W + 1)'(PADDLE_HEIGHT);

    localparam logic [CNT_W-1:0]   PERIOD_INIT = CNT_W'(BALL_PERIOD);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [SRV_W-1:0]   SERVE_LAST  = SRV_W'(SERVE_STEPS - 1);
    localparam logic [SRV_W-1:0]   SRV_ONE     = SRV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_MOVE  = 2'd2,
        ST_MISS  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SRV_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic [COORD_W-1:0] ball_x_q, ball_x_d;
    logic [COORD_W-1:0] ball_y_q, ball_y_d;
    logic               dir_x_q, dir_x_d;   // 1 = right
    logic               dir_y_q, dir_y_d;   // 1 = down
    logic               hit_q, hit_d;
    logic               score1_q, score1_d;
    logic               score2_q, score2_d;
    logic               miss_d;
    logic               draw_q;
    logic [CNT_W-1:0]   period;
    logic               tick;
    logic               p1_cover;
    logic               p2_cover;

    // ------------------------------------------------------------------------
    // Step period: fixed, or shortened by paddle hits when speed-up is built.
    // ------------------------------------------------------------------------
`ifdef BALL_SPEEDUP_EN
    localparam logic [CNT_W-1:0] PERIOD_MIN_C = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] STEP_C       = CNT_W'(SPEEDUP_STEP);
    // Subtracting is only safe while period >= MIN_PERIOD + SPEEDUP_STEP;
    // below that the result is clamped to the floor.
    localparam logic [CNT_W:0]   DEC_LIMIT    = (CNT_W + 1)'(MIN_PERIOD + SPEEDUP_STEP);

    logic [CNT_W-1:0] period_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            period_q <= PERIOD_INIT;
        end else if (state_d == ST_IDLE || state_d == ST_MISS) begin
            period_q <= PERIOD_INIT;
        end else if (hit_d) begin
            period_q <= ({1'b0, period_q} >= DEC_LIMIT) ? (period_q - STEP_C) : PERIOD_MIN_C;
        end
    end

    assign period = period_q;
`else
    assign period = PERIOD_INIT;
`endif

    // A hit changes the period on the same edge the counter wraps to 0, so
    // the counter never sits above a freshly shortened period.
    assign tick = (cnt_q == (period - CNT_ONE));

    // Paddle span compare is one bit wider so top + length cannot wrap.
    assign p1_cover = ({1'b0, ball_y_q} >= {1'b0, Paddle_Y_P1_i}) &&
                      ({1'b0, ball_y_q} <  ({1'b0, Paddle_Y_P1_i} + PAD_LEN));
    assign p2_cover = ({1'b0, ball_y_q} >= {1'b0, Paddle_Y_P2_i}) &&
                      ({1'b0, ball_y_q} <  ({1'b0, Paddle_Y_P2_i} + PAD_LEN));

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            serve_cnt_q <= '0;
            ball_x_q    <= CENTRE_X;
            ball_y_q    <= CENTRE_Y;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            hit_q       <= 1'b0;
            score1_q    <= 1'b0;
            score2_q    <= 1'b0;
            draw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            serve_cnt_q <= serve_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            hit_q       <= hit_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            // Compares against the position held before this edge's move.
            draw_q      <= (col_count_div_i == ball_x_q) && (row_count_div_i == ball_y_q);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        serve_cnt_d = serve_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        hit_d       = 1'b0;
        score1_d    = 1'b0;
        score2_d    = 1'b0;
        miss_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d       = '0;
                serve_cnt_d = '0;
                ball_x_d    = CENTRE_X;
                ball_y_d    = CENTRE_Y;
                dir_x_d     = Serve_Dir_i;
                dir_y_d     = 1'b1;
                if (Game_Active_i) begin
                    state_d = ST_SERVE;
                end
            end

            ST_SERVE: begin
                cnt_d = tick ? '0 : (cnt_q + CNT_ONE);
                if (tick) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        serve_cnt_d = '0;
                        state_d     = ST_MOVE;
                    end else begin
                        serve_cnt_d = serve_cnt_q + SRV_ONE;
                    end
                end
            end

            ST_MOVE: begin
                cnt_d = tick ? '0 : (cnt_q + CNT_ONE);
                if (tick) begin
                    // X: paddle bounces take priority over the edge-of-board miss.
                    if (!dir_x_q && (ball_x_q == P1_HIT_X) && p1_cover) begin
                        dir_x_d  = 1'b1;
                        ball_x_d = ball_x_q + POS_ONE;
                        hit_d    = 1'b1;
                    end else if (dir_x_q && (ball_x_q == P2_HIT_X) && p2_cover) begin
                        dir_x_d  = 1'b0;
                        ball_x_d = ball_x_q - POS_ONE;
                        hit_d    = 1'b1;
                    end else if (!dir_x_q && (ball_x_q == '0)) begin
                        score2_d = 1'b1;
                        miss_d   = 1'b1;
                    end else if (dir_x_q && (ball_x_q == X_MAX)) begin
                        score1_d = 1'b1;
                        miss_d   = 1'b1;
                    end else begin
                        ball_x_d = dir_x_q ? (ball_x_q + POS_ONE) : (ball_x_q - POS_ONE);
                    end

                    // Y: wall bounce flips direction and steps away from the wall.
                    if (!dir_y_q && (ball_y_q == '0)) begin
                        dir_y_d  = 1'b1;
                        ball_y_d = ball_y_q + POS_ONE;
                    end else if (dir_y_q && (ball_y_q == Y_MAX)) begin
                        dir_y_d  = 1'b0;
                        ball_y_d = ball_y_q - POS_ONE;
                    end else begin
                        ball_y_d = dir_y_q ? (ball_y_q + POS_ONE) : (ball_y_q - POS_ONE);
                    end

                    // A miss re-centres immediately and serves toward the
                    // player who let the ball through (score1 => P2 missed).
                    if (miss_d) begin
                        state_d  = ST_MISS;
                        cnt_d    = '0;
                        ball_x_d = CENTRE_X;
                        ball_y_d = CENTRE_Y;
                        dir_y_d  = 1'b1;
                        dir_x_d  = score1_d;
                    end
                end
            end

            ST_MISS: begin
                cnt_d       = '0;
                serve_cnt_d = '0;
                state_d     = ST_SERVE;
            end
        endcase

        // Losing the game enable overrides everything, including a move or
        // pulse that would otherwise happen on this edge.
        if (!Game_Active_i) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            serve_cnt_d = '0;
            ball_x_d    = CENTRE_X;
            ball_y_d    = CENTRE_Y;
            dir_x_d     = Serve_Dir_i;
            dir_y_d     = 1'b1;
            hit_d       = 1'b0;
            score1_d    = 1'b0;
            score2_d    = 1'b0;
        end
    end

    assign Draw_Ball_o = draw_q;
    assign Ball_X_o    = ball_x_q;
    assign Ball_Y_o    = ball_y_q;
    assign Hit_o       = hit_q;
    assign Score_P1_o  = score1_q;
    assign Score_P2_o  = score2_q;
    assign dbg_state_o = state_q;

endmodule
